// File: rtl/fmo_writeback.sv
// FMO tile writeback: reads a finished tile out of the FMO RAM and packs it into valid/ready bus words.
// Define FMO_WB_RELU_EN to clamp negative pixels to zero on the way out.

package irb_pkg;
   localparam int unsigned PX_W       = 8;
   localparam int unsigned FMO_N_ELEM = 64;
endpackage

module fmo_writeback #(
   parameter int unsigned PX_W        = irb_pkg::PX_W,
   parameter int unsigned N_ELEM      = irb_pkg::FMO_N_ELEM,
   parameter int unsigned PX_PER_WORD = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [$clog2(N_ELEM+1)-1:0]     n_px,
   output logic [$clog2(N_ELEM)-1:0]       ram_addr,
   input  logic [PX_W-1:0]                 ram_res,
   output logic [PX_W*PX_PER_WORD-1:0]     wb_data,
   output logic [PX_PER_WORD-1:0]          wb_keep,
   output logic                            wb_last,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned CNT_W  = $clog2(N_ELEM+1);
   localparam int unsigned ADDR_W = $clog2(N_ELEM);
   localparam int unsigned DATA_W = PX_W*PX_PER_WORD;
   localparam int unsigned LANE_W = $clog2(PX_PER_WORD+1);

   typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_px_q, n_px_d;
   logic [CNT_W-1:0]    px_q, px_d;
   logic [LANE_W-1:0]   iss_q, iss_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [PX_PER_WORD-1:0] wb_keep_q, wb_keep_d;
   logic                wb_last_q, wb_last_d;
   logic                wb_valid_q, wb_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PX_W-1:0]     px_val;

   // Pixel as it will be packed into the word
   always_comb begin
      px_val = ram_res;
`ifdef FMO_WB_RELU_EN
      if (ram_res[PX_W-1]) px_val = '0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      n_px_d     = n_px_q;
      px_d       = px_q;
      iss_d      = iss_q;
      lane_d     = lane_q;
      pend_d     = 1'b0;
      ram_addr_d = ram_addr_q;
      wb_data_d  = wb_data_q;
      wb_keep_d  = wb_keep_q;
      wb_last_d  = wb_last_q;
      wb_valid_d = wb_valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // pend_q: the RAM is returning data for the address issued last cycle
      if (pend_q) begin
         for (int k = 0; k < int'(PX_PER_WORD); k++) begin
            if (lane_q == LANE_W'(k)) begin
               wb_data_d[k*PX_W +: PX_W] = px_val;
               wb_keep_d[k]              = 1'b1;
            end
         end
         lane_d = lane_q + LANE_W'(1);
      end

      // px counts addresses already issued; iss is the lane of the address on ram_addr
      case (state_q)
         IDLE: begin
            if (start) begin
               n_px_d    = (n_px > CNT_W'(N_ELEM)) ? CNT_W'(N_ELEM) : n_px;
               iss_d     = '0;
               lane_d    = '0;
               wb_data_d = '0;
               wb_keep_d = '0;
               wb_last_d = 1'b0;
               if (n_px_d == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = RD;
                  busy_d     = 1'b1;
                  ram_addr_d = '0;
                  px_d       = CNT_W'(1);
               end
            end
         end
         RD: begin
            pend_d = 1'b1;
            if (iss_q == LANE_W'(PX_PER_WORD-1) || px_q == n_px_q) begin
               state_d = CAP;
            end else begin
               ram_addr_d = ADDR_W'(px_q);
               px_d       = px_q + CNT_W'(1);
               iss_d      = iss_q + LANE_W'(1);
            end
         end
         CAP: begin
            state_d    = SEND;
            wb_valid_d = 1'b1;
            wb_last_d  = (px_q == n_px_q);
         end
         SEND: begin
            if (wb_ready) begin
               wb_valid_d = 1'b0;
               wb_data_d  = '0;
               wb_keep_d  = '0;
               wb_last_d  = 1'b0;
               lane_d     = '0;
               iss_d      = '0;
               if (px_q == n_px_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = RD;
                  ram_addr_d = ADDR_W'(px_q);
                  px_d       = px_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_px_q     <= '0;
         px_q       <= '0;
         iss_q      <= '0;
         lane_q     <= '0;
         pend_q     <= 1'b0;
         ram_addr_q <= '0;
         wb_data_q  <= '0;
         wb_keep_q  <= '0;
         wb_last_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_px_q     <= n_px_d;
         px_q       <= px_d;
         iss_q      <= iss_d;
         lane_q     <= lane_d;
         pend_q     <= pend_d;
         ram_addr_q <= ram_addr_d;
         wb_data_q  <= wb_data_d;
         wb_keep_q  <= wb_keep_d;
         wb_last_q  <= wb_last_d;
         wb_valid_q <= wb_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign wb_data  = wb_data_q;
   assign wb_keep  = wb_keep_q;
   assign wb_last  = wb_last_q;
   assign wb_valid = wb_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fmo_writeback.sv
// Bench for fmo_writeback: vector table, hand-written reset/sign sequences and randomized tiles
// checked against a tile-level packing model.

module tb_fmo_writeback;

   localparam int unsigned PX_W   = 8;
   localparam int unsigned N_ELEM = 64;
   localparam int unsigned PPW    = 4;
   localparam int unsigned CNT_W  = $clog2(N_ELEM+1);
   localparam int unsigned ADDR_W = $clog2(N_ELEM);
   localparam int unsigned DW     = PX_W*PPW;

`ifdef FMO_WB_RELU_EN
   localparam logic [DW-1:0] SIGN_EXP = 32'h00007F00;
`else
   localparam logic [DW-1:0] SIGN_EXP = 32'h00007F80;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [CNT_W-1:0]  n_px;
   logic [ADDR_W-1:0] ram_addr;
   logic [PX_W-1:0]   ram_res;
   logic [DW-1:0]     wb_data;
   logic [PPW-1:0]    wb_keep;
   logic              wb_last;
   logic              wb_valid;
   logic              wb_ready;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   logic [PX_W-1:0] mem [N_ELEM];

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [PPW-1:0] keep;
      logic           last;
   } beat_t;

   beat_t exp_q[$];

   typedef struct {
      int             n;
      int             pct;
      int             stall;
      int             restart;
      int             words;
      logic [DW-1:0]  first_d;
      logic [DW-1:0]  last_d;
      logic [PPW-1:0] keep;
      int             addr;
   } vec_t;

   fmo_writeback #(.PX_W(PX_W), .N_ELEM(N_ELEM), .PX_PER_WORD(PPW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_px(n_px),
      .ram_addr(ram_addr), .ram_res(ram_res),
      .wb_data(wb_data), .wb_keep(wb_keep), .wb_last(wb_last),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // One-cycle-latency RAM
   always @(posedge clk) ram_res <= mem[ram_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string info);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, info);
   endtask

   function automatic logic [PX_W-1:0] relu(input logic [PX_W-1:0] x);
`ifdef FMO_WB_RELU_EN
      if ($signed(x) < 0) return '0;
`endif
      return x;
   endfunction

   // Expected word stream: pixels 0..eff-1 grouped PPW to a word, lane 0 lowest address
   task automatic build_model(input int n);
      int    eff;
      int    nw;
      beat_t b;
      eff = (n > int'(N_ELEM)) ? int'(N_ELEM) : n;
      nw  = (eff + int'(PPW) - 1) / int'(PPW);
      exp_q.delete();
      for (int w = 0; w < nw; w++) begin
         b = '0;
         for (int k = 0; k < int'(PPW); k++) begin
            if (w*int'(PPW) + k < eff) begin
               b.data[k*PX_W +: PX_W] = relu(mem[w*int'(PPW) + k]);
               b.keep[k] = 1'b1;
            end
         end
         b.last = (w == nw - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic run_xfer(input int n, input int pct, input int stall, input int restart,
                           output int beats, output logic [DW-1:0] first_data,
                           output logic [DW-1:0] last_data, output logic [PPW-1:0] last_keep,
                           output int end_addr);
      int                eff;
      int                last_hs;
      int                first_valid;
      int                stall_left;
      logic              got_done;
      logic              prev_valid;
      logic              prev_ready;
      logic [DW-1:0]     prev_data;
      logic [PPW-1:0]    prev_keep;
      logic              prev_last;
      logic [ADDR_W-1:0] prev_addr;
      beat_t             b;
      eff = (n > int'(N_ELEM)) ? int'(N_ELEM) : n;
      build_model(n);
      beats = 0; first_data = '0; last_data = '0; last_keep = '0;
      last_hs = 0; first_valid = -1; stall_left = stall; got_done = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_keep = '0;
      prev_last = 1'b0; prev_addr = '0;
      start = 1'b1; n_px = CNT_W'(n); wb_ready = 1'b0;
      @(posedge clk); #1;
      for (int cyc = 1; cyc < 3000; cyc++) begin
         start = (cyc == restart);
         n_px  = CNT_W'(3);
         if (wb_valid && first_valid < 0) first_valid = cyc;
         if (prev_valid && !prev_ready) begin
            chk("stall_valid", 64'(wb_valid), 64'(1));
            chk("stall_data", 64'(wb_data), 64'(prev_data));
            chk("stall_keep", 64'(wb_keep), 64'(prev_keep));
            chk("stall_last", 64'(wb_last), 64'(prev_last));
            chk("stall_addr", 64'(ram_addr), 64'(prev_addr));
         end
         if (done) begin
            chk("done_cycle", 64'(cyc), 64'(last_hs + 1));
            chk("busy_at_done", 64'(busy), 64'(0));
            got_done = 1'b1;
            break;
         end
         chk("busy_high", 64'(busy), 64'(1));
         if (stall_left > 0 && wb_valid) begin
            wb_ready = 1'b0;
            stall_left--;
         end else begin
            wb_ready = ($urandom_range(99) < 32'(pct));
         end
         if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               fail("extra_beat", $sformatf("beat %0d data 0x%0h not expected", beats, wb_data));
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", 64'(wb_data), 64'(b.data));
               chk("beat_keep", 64'(wb_keep), 64'(b.keep));
               chk("beat_last", 64'(wb_last), 64'(b.last));
            end
            if (beats == 0) first_data = wb_data;
            last_data = wb_data;
            last_keep = wb_keep;
            beats++;
            last_hs = cyc;
         end
         prev_valid = wb_valid; prev_ready = wb_ready; prev_data = wb_data;
         prev_keep = wb_keep; prev_last = wb_last; prev_addr = ram_addr;
         @(posedge clk); #1;
      end
      start = 1'b0; wb_ready = 1'b0;
      if (!got_done) fail("done_timeout", $sformatf("no done for n_px=%0d", n));
      chk("model_drained", 64'(exp_q.size()), 64'(0));
      if (eff >= int'(PPW)) chk("first_valid_lat", 64'(first_valid), 64'(PPW + 2));
      end_addr = int'(ram_addr);
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'(0));
   endtask

   initial begin
      vec_t           vecs[9];
      int             beats;
      int             end_addr;
      logic [DW-1:0]  fd;
      logic [DW-1:0]  ld;
      logic [PPW-1:0] lk;

      vecs[0] = '{n:8,   pct:100, stall:0, restart:0, words:2,  first_d:32'h03020100, last_d:32'h07060504, keep:4'hF, addr:7};
      vecs[1] = '{n:6,   pct:100, stall:0, restart:0, words:2,  first_d:32'h03020100, last_d:32'h00000504, keep:4'h3, addr:5};
      vecs[2] = '{n:8,   pct:100, stall:5, restart:0, words:2,  first_d:32'h03020100, last_d:32'h07060504, keep:4'hF, addr:7};
      vecs[3] = '{n:0,   pct:100, stall:0, restart:0, words:0,  first_d:32'h0,        last_d:32'h0,        keep:4'h0, addr:0};
      vecs[4] = '{n:100, pct:100, stall:0, restart:0, words:16, first_d:32'h03020100, last_d:32'h3F3E3D3C, keep:4'hF, addr:63};
      vecs[5] = '{n:8,   pct:100, stall:0, restart:3, words:2,  first_d:32'h03020100, last_d:32'h07060504, keep:4'hF, addr:7};
      vecs[6] = '{n:13,  pct:50,  stall:0, restart:0, words:4,  first_d:32'h03020100, last_d:32'h0000000C, keep:4'h1, addr:12};
      vecs[7] = '{n:1,   pct:100, stall:0, restart:0, words:1,  first_d:32'h00000000, last_d:32'h00000000, keep:4'h1, addr:0};
      vecs[8] = '{n:64,  pct:40,  stall:3, restart:9, words:16, first_d:32'h03020100, last_d:32'h3F3E3D3C, keep:4'hF, addr:63};

      for (int i = 0; i < int'(N_ELEM); i++) mem[i] = PX_W'(i);
      rst_n = 1'b0; start = 1'b0; n_px = '0; wb_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_addr", 64'(ram_addr), 64'(0));
      chk("rst_wb_data",  64'(wb_data),  64'(0));
      chk("rst_wb_keep",  64'(wb_keep),  64'(0));
      chk("rst_wb_last",  64'(wb_last),  64'(0));
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_done",     64'(done),     64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 9; v++) begin
         run_xfer(vecs[v].n, vecs[v].pct, vecs[v].stall, vecs[v].restart, beats, fd, ld, lk, end_addr);
         chk($sformatf("vec%0d_words", v), 64'(beats), 64'(vecs[v].words));
         if (vecs[v].words > 0) begin
            chk($sformatf("vec%0d_first", v), 64'(fd), 64'(vecs[v].first_d));
            chk($sformatf("vec%0d_last", v), 64'(ld), 64'(vecs[v].last_d));
            chk($sformatf("vec%0d_keep", v), 64'(lk), 64'(vecs[v].keep));
            chk($sformatf("vec%0d_addr", v), 64'(end_addr), 64'(vecs[v].addr));
         end
      end

      // Reset while a word is waiting in SEND
      start = 1'b1; n_px = CNT_W'(8); wb_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20 && !wb_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_valid", 64'(wb_valid), 64'(1));
      chk("pre_rst_addr", 64'(ram_addr), 64'(3));
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_ram_addr", 64'(ram_addr), 64'(0));
      chk("mid_rst_wb_data",  64'(wb_data),  64'(0));
      chk("mid_rst_wb_keep",  64'(wb_keep),  64'(0));
      chk("mid_rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("mid_rst_busy",     64'(busy),     64'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_done",  64'(done),     64'(0));
         chk("post_rst_valid", 64'(wb_valid), 64'(0));
      end
      run_xfer(4, 100, 0, 0, beats, fd, ld, lk, end_addr);
      chk("post_rst_words", 64'(beats), 64'(1));
      chk("post_rst_data",  64'(fd),    64'(32'h03020100));
      chk("post_rst_keep",  64'(lk),    64'(4'hF));

      // Sign handling
      mem[0] = 8'h80; mem[1] = 8'h7F;
      run_xfer(2, 100, 0, 0, beats, fd, ld, lk, end_addr);
      chk("sign_data", 64'(fd), 64'(SIGN_EXP));
      chk("sign_keep", 64'(lk), 64'(4'h3));

      // Random tiles against the model
      for (int r = 0; r < 12; r++) begin
         int n;
         for (int i = 0; i < int'(N_ELEM); i++) mem[i] = PX_W'($urandom);
         n = int'($urandom_range(80));
         run_xfer(n, int'($urandom_range(100, 20)), int'($urandom_range(3)), int'($urandom_range(12)),
                  beats, fd, ld, lk, end_addr);
         chk($sformatf("rand%0d_words", r), 64'(beats),
             64'(((n > int'(N_ELEM) ? int'(N_ELEM) : n) + int'(PPW) - 1) / int'(PPW)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
